// File: rtl/mux_rr_pkg.sv
// rtl/mux_rr_pkg.sv - shared types and round-robin pick helper for mux_rr_nto1
package mux_rr_pkg;

  localparam int RR_MAX_N = 32;
  localparam int RR_IDXW  = $clog2(RR_MAX_N);

  typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_state_e;

  // One-hot grant: first set bit of valid found scanning upward from ptr, wrapping at n.
  function automatic logic [RR_MAX_N-1:0] rr_pick(input logic [RR_MAX_N-1:0] valid,
                                                  input int unsigned ptr,
                                                  input int unsigned n);
    logic [RR_MAX_N-1:0] g;
    logic found;
    int unsigned idx;
    g = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX_N; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && valid[idx[RR_IDXW-1:0]]) begin
        g[idx[RR_IDXW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mux_rr_nto1_arbiter.sv
// rtl/mux_rr_nto1_arbiter.sv - round-robin arbiter (rr_arbiter) holding the priority pointer
module rr_arbiter
  import mux_rr_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            adv,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  logic [RR_MAX_N-1:0] w_pick;
  logic [SELW-1:0]     w_ptr;
  logic [SELW-1:0]     w_idx;

  assign w_pick = rr_pick(RR_MAX_N'(req), 32'(w_ptr), unsigned'(N));
  assign grant  = w_pick[N-1:0];

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < RR_MAX_N; i++) begin
      if (w_pick[i]) w_idx = SELW'(i);
    end
  end
  assign grant_idx = w_idx;

  generate
    if (N > 1) begin : g_ptr
      logic [SELW-1:0] r_ptr;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_ptr <= '0;
        end else if (adv) begin
          r_ptr <= (w_idx == SELW'(N-1)) ? '0 : w_idx + SELW'(1);
        end
      end
      assign w_ptr = r_ptr;
    end else begin : g_noptr
      assign w_ptr = '0;
    end
  endgenerate

endmodule

// File: rtl/mux_rr_nto1.sv
// rtl/mux_rr_nto1.sv - N:1 registered round-robin mux with valid/ready handshakes
// Optional packet lock compiled in with MUX_RR_PKT_LOCK_EN.
module mux_rr_nto1
  import mux_rr_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  output logic            out_last,
  output logic [SELW-1:0] out_sel,
  input  logic            out_ready
);

  logic            w_load_en;
  logic            w_in_xfer;
  logic            w_adv;
  logic [N-1:0]    w_req;
  logic [N-1:0]    w_grant;
  logic [SELW-1:0] w_idx;
  logic [W-1:0]    w_data;
  logic            w_last;

  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic            r_out_last;
  logic [SELW-1:0] r_out_sel;

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (w_req),
    .adv       (w_adv),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  // Gating with rst_n keeps every handshake closed while reset is held.
  assign w_load_en = rst_n & (~r_out_valid | out_ready);
  assign in_ready  = w_grant & {N{w_load_en}};
  assign w_in_xfer = |(in_valid & in_ready);

  always_comb begin
    w_data = '0;
    w_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_data = w_data | in_data[i*W +: W];
        w_last = w_last | in_last[i];
      end
    end
  end

`ifdef MUX_RR_PKT_LOCK_EN
  lock_state_e     r_lock_state;
  lock_state_e     w_lock_next;
  logic [SELW-1:0] r_lock_ch;

  always_comb begin
    w_req = in_valid;
    if (r_lock_state == LOCK_HELD) begin
      w_req = '0;
      w_req[r_lock_ch] = in_valid[r_lock_ch];
    end
  end

  always_comb begin
    w_lock_next = r_lock_state;
    case (r_lock_state)
      LOCK_IDLE: if (w_in_xfer && !w_last) w_lock_next = LOCK_HELD;
      LOCK_HELD: if (w_in_xfer && w_last)  w_lock_next = LOCK_IDLE;
      default:   w_lock_next = LOCK_IDLE;
    endcase
  end

  // Pointer moves only at packet boundaries so a locked packet does not consume turns.
  assign w_adv = w_in_xfer & w_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_state <= LOCK_IDLE;
      r_lock_ch    <= '0;
    end else begin
      r_lock_state <= w_lock_next;
      if (r_lock_state == LOCK_IDLE && w_in_xfer && !w_last) r_lock_ch <= w_idx;
    end
  end
`else
  assign w_req = in_valid;
  assign w_adv = w_in_xfer;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_last  <= w_last;
      r_out_sel   <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// tb/tb_mux_rr_nto1.sv - directed table-driven bench for mux_rr_nto1 (N=4 and N=1 instances)
module tb_mux_rr_nto1;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_last, in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid, out_last, out_ready;
  logic [1:0]     out_sel;

  logic [W-1:0] d1, od1;
  logic         v1, l1, r1, ov1, ol1, ordy1;
  logic [0:0]   os1;

  mux_rr_nto1 #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  mux_rr_nto1 #(.N(1), .W(W)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_last(l1),
    .in_ready(r1), .out_data(od1), .out_valid(ov1), .out_last(ol1),
    .out_sel(os1), .out_ready(ordy1)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  er;
    logic        eov;
    logic [7:0]  eod;
    logic [1:0]  es;
  } vec_t;

  vec_t tbl[17];
  int   exp_sel[4];
  int   exp_last[4];
  int   exp_rdy[4];
  int   cnt;

  initial begin
    tbl[0]  = '{4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl[1]  = '{4'b1111, 32'h44332211, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[2]  = '{4'b1111, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[3]  = '{4'b1111, 32'h44332211, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[4]  = '{4'b1111, 32'h44332211, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    tbl[5]  = '{4'b1111, 32'h44332211, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[6]  = '{4'b1111, 32'h55667788, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
    tbl[7]  = '{4'b1111, 32'h55667788, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
    tbl[8]  = '{4'b1111, 32'h55667788, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
    tbl[9]  = '{4'b1111, 32'h55667788, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
    tbl[10] = '{4'b1111, 32'h55667788, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
    tbl[11] = '{4'b1111, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[12] = '{4'b0000, 32'h44332211, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
    tbl[13] = '{4'b0000, 32'h44332211, 1'b0, 4'b0000, 1'b0, 8'h11, 2'd0};
    tbl[14] = '{4'b1001, 32'h44332211, 1'b0, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[15] = '{4'b1001, 32'h99332288, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
    tbl[16] = '{4'b0000, 32'h44332211, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd3};

`ifdef MUX_RR_PKT_LOCK_EN
    exp_sel  = '{1, 1, 1, 0};
    exp_last = '{0, 0, 1, 1};
    exp_rdy  = '{2, 2, 2, 1};
`else
    exp_sel  = '{1, 0, 1, 0};
    exp_last = '{0, 1, 0, 1};
    exp_rdy  = '{2, 1, 2, 1};
`endif

    rst_n = 1'b0; in_valid = '1; in_data = '0; in_last = '1; out_ready = 1'b1;
    v1 = 1'b1; d1 = 8'hFF; l1 = 1'b0; ordy1 = 1'b1;
    tick;
    tick;
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", 32'(out_data), 0);
    chk("rst out_last", 32'(out_last), 0);
    chk("rst out_sel", 32'(out_sel), 0);
    chk("rst n1 in_ready", 32'(r1), 0);
    chk("rst n1 out_valid", 32'(ov1), 0);
    rst_n = 1'b1; in_valid = '0; v1 = 1'b0;

    for (int i = 0; i < 17; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].er));
      tick;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(tbl[i].eod));
      chk($sformatf("v%0d out_sel", i), 32'(out_sel), 32'(tbl[i].es));
      chk($sformatf("v%0d out_last", i), 32'(out_last), 1);
    end

    // Reset in the middle of traffic, then ch0 must win the tie with ch3.
    in_valid = 4'b0010; in_data = 32'h44332211; out_ready = 1'b0;
    #1; chk("t5 load ready", 32'(in_ready), 32'b0010);
    tick;
    chk("t5 pre out_valid", 32'(out_valid), 1);
    chk("t5 pre out_data", 32'(out_data), 32'h22);
    rst_n = 1'b0; in_valid = 4'b1001;
    #1; chk("t5 rst ready", 32'(in_ready), 0);
    tick;
    chk("t5 rst out_valid", 32'(out_valid), 0);
    chk("t5 rst out_data", 32'(out_data), 0);
    chk("t5 rst out_sel", 32'(out_sel), 0);
    rst_n = 1'b1; out_ready = 1'b1;
    #1; chk("t5 tie ready", 32'(in_ready), 32'b0001);
    tick;
    chk("t5 tie out_sel", 32'(out_sel), 0);
    chk("t5 tie out_data", 32'(out_data), 32'h11);

    // Three-word packet on ch1 competing with single-word traffic on ch0.
    in_valid = 4'b0011; in_data = 32'h0000B1A0; out_ready = 1'b1; cnt = 0;
    for (int k = 0; k < 4; k++) begin
      in_last = {2'b11, (cnt == 2), 1'b1};
      #1; chk($sformatf("t4 c%0d in_ready", k), 32'(in_ready), 32'(exp_rdy[k]));
      tick;
      chk($sformatf("t4 c%0d out_sel", k), 32'(out_sel), 32'(exp_sel[k]));
      chk($sformatf("t4 c%0d out_last", k), 32'(out_last), 32'(exp_last[k]));
      chk($sformatf("t4 c%0d out_data", k), 32'(out_data), (exp_sel[k] == 1) ? 32'hB1 : 32'hA0);
      if (exp_sel[k] == 1) cnt++;
    end
    in_valid = '0; in_last = '1;
    tick;

    // Single-channel instance behaves as a one-deep pipeline register.
    v1 = 1'b1; d1 = 8'h3C; ordy1 = 1'b1;
    #1; chk("n1 a ready", 32'(r1), 1);
    tick;
    chk("n1 a out_valid", 32'(ov1), 1);
    chk("n1 a out_data", 32'(od1), 32'h3C);
    chk("n1 a out_sel", 32'(os1), 0);
    d1 = 8'h5A; ordy1 = 1'b0;
    #1; chk("n1 b ready", 32'(r1), 0);
    tick;
    chk("n1 b out_data", 32'(od1), 32'h3C);
    ordy1 = 1'b1;
    #1; chk("n1 c ready", 32'(r1), 1);
    tick;
    chk("n1 c out_data", 32'(od1), 32'h5A);
    chk("n1 c out_sel", 32'(os1), 0);
    v1 = 1'b0;
    tick;
    chk("n1 d out_valid", 32'(ov1), 0);
    chk("n1 d out_data", 32'(od1), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
